// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: control bundle layout and the NOP encoding.
package pipe_pkg;
   localparam int DEF_CTRL_W = 9;
   localparam int DEF_DATA_W = 148;

   // Control bundle bit positions (one bit each)
   localparam int CTRL_REGDST   = 0;
   localparam int CTRL_ALUSRC   = 1;
   localparam int CTRL_MEMTOREG = 2;
   localparam int CTRL_REGWRITE = 3;
   localparam int CTRL_MEMREAD  = 4;
   localparam int CTRL_MEMWRITE = 5;
   localparam int CTRL_BRANCH   = 6;
   localparam int CTRL_JUMP     = 7;
   localparam int CTRL_ALUOP    = 8;

   localparam logic [DEF_CTRL_W-1:0] CTRL_NOP = '0;
endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding register: valid flag, control bundle and data bundle.
// clear wins over load; an invalid slot always holds NOP control.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int CTRL_W     = DEF_CTRL_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CLEAR_DATA = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         ctrl  <= CTRL_W'(CTRL_NOP);
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= CTRL_W'(CTRL_NOP);
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= d_ctrl;
      end
   end

   // Data only carries a reset/clear when the consumer cares about stale payloads
   generate
      if (CLEAR_DATA != 0) begin : g_clr
         always_ff @(posedge clk or posedge rst) begin
            if (rst)        data <= '0;
            else if (clear) data <= '0;
            else if (load)  data <= d_data;
         end
      end else begin : g_stale
         always_ff @(posedge clk) begin
            if (load && !clear) data <= d_data;
         end
      end
   endgenerate
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a 2-entry skid buffer, flush and per-beat kill.
// in_ready is derived only from the skid flop, so out_ready never reaches it combinationally.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W     = DEF_CTRL_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CLEAR_DATA = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_kill,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);
   logic              main_vld, skid_vld;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data, skid_data;
   logic              acc, pop;
   logic              main_load, main_clear, skid_load, skid_clear;
   logic [CTRL_W-1:0] main_d_ctrl;
   logic [DATA_W-1:0] main_d_data;

   assign in_ready  = ~skid_vld;
   assign acc       = in_valid & in_ready & ~in_kill;
   assign pop       = main_vld & out_ready;

   // A full skid always refills main on pop; acc cannot coincide with it
   assign main_load  = ~flush & ((pop & skid_vld) | ((~main_vld | pop) & acc));
   assign main_clear = flush | (pop & ~main_load);
   assign skid_load  = ~flush & main_vld & ~pop & acc;
   assign skid_clear = flush | (pop & skid_vld);

   assign main_d_ctrl = skid_vld ? skid_ctrl : in_ctrl;
   assign main_d_data = skid_vld ? skid_data : in_data;

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
      .clk    (clk),
      .rst    (rst),
      .load   (main_load),
      .clear  (main_clear),
      .d_ctrl (main_d_ctrl),
      .d_data (main_d_data),
      .valid  (main_vld),
      .ctrl   (main_ctrl),
      .data   (main_data)
   );

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (skid_load),
      .clear  (skid_clear),
      .d_ctrl (in_ctrl),
      .d_data (in_data),
      .valid  (skid_vld),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
   );

   assign out_valid = main_vld;
   assign out_ctrl  = main_vld ? main_ctrl : CTRL_W'(CTRL_NOP);
   assign out_data  = main_data;
   assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_stage_skid;
   localparam int CW = 9;
   localparam int DW = 148;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_kill, flush, out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          in_ready, out_valid;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } beat_t;
   beat_t q[$];

   always #5 clk = ~clk;

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_kill   (in_kill),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the stage is a FIFO of at most two beats
   always @(posedge clk or posedge rst) begin
      if (rst) q.delete();
      else if (flush) q.delete();
      else begin
         logic can_take;
         can_take = (q.size() < 2);
         if (out_ready && q.size() > 0) void'(q.pop_front());
         if (in_valid && can_take && !in_kill) q.push_back('{c: in_ctrl, d: in_data});
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready",  160'(in_ready),  160'(q.size() < 2));
         chk("out_valid", 160'(out_valid), 160'(q.size() > 0));
         chk("occupancy", 160'(occupancy), 160'(q.size()));
         chk("out_ctrl",  160'(out_ctrl),  (q.size() > 0) ? 160'(q[0].c) : 160'(0));
         if (q.size() > 0) chk("out_data", 160'(out_data), 160'(q[0].d));
      end
   end

   task automatic drive(input logic v, input logic k, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic ordy, input logic fl);
      in_valid = v; in_kill = k; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, '0, '0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 160'(in_ready), 160'(1));
      chk("rst_out_valid", 160'(out_valid), 160'(0));
      chk("rst_occ", 160'(occupancy), 160'(0));

      // Streaming: one beat per cycle, one cycle latency
      drive(1, 0, 9'h011, 148'hA, 1, 0);
      @(negedge clk); chk("strm_A", 160'(out_ctrl), 160'(9'h011));
      drive(1, 0, 9'h022, 148'hB, 1, 0);
      @(negedge clk); chk("strm_B", 160'(out_ctrl), 160'(9'h022));
      drive(1, 0, 9'h033, 148'hC, 1, 0);
      @(negedge clk); chk("strm_C", 160'(out_ctrl), 160'(9'h033));
      chk("strm_C_data", 160'(out_data), 160'(148'hC));
      drive(0, 0, '0, '0, 1, 0);
      @(negedge clk); chk("strm_empty", 160'(out_valid), 160'(0));

      // Stall: A in main, B in skid, C held upstream
      drive(1, 0, 9'h041, 148'h41, 0, 0);
      @(negedge clk); chk("stall_occ1", 160'(occupancy), 160'(1));
      drive(1, 0, 9'h042, 148'h42, 0, 0);
      @(negedge clk); chk("stall_occ2", 160'(occupancy), 160'(2));
      chk("stall_rdy0", 160'(in_ready), 160'(0));
      drive(1, 0, 9'h043, 148'h43, 0, 0);
      @(negedge clk); chk("stall_hold", 160'(out_ctrl), 160'(9'h041));
      chk("stall_occ2b", 160'(occupancy), 160'(2));
      drive(1, 0, 9'h043, 148'h43, 1, 0);
      @(negedge clk); chk("drain_B", 160'(out_ctrl), 160'(9'h042));
      chk("drain_rdy", 160'(in_ready), 160'(1));
      @(negedge clk); chk("drain_C", 160'(out_ctrl), 160'(9'h043));
      drive(0, 0, '0, '0, 1, 0);
      @(negedge clk); chk("drain_empty", 160'(occupancy), 160'(0));

      // Flush with two held beats and a live input
      drive(1, 0, 9'h051, 148'h51, 0, 0);
      @(negedge clk); drive(1, 0, 9'h052, 148'h52, 0, 0);
      @(negedge clk); chk("fl_occ2", 160'(occupancy), 160'(2));
      drive(1, 0, 9'h053, 148'h53, 0, 1);
      @(negedge clk); chk("fl_occ0", 160'(occupancy), 160'(0));
      chk("fl_ctrl0", 160'(out_ctrl), 160'(0));
      drive(0, 0, '0, '0, 1, 0);
      @(negedge clk); chk("fl_no_emit", 160'(out_valid), 160'(0));

      // Kill: beats consumed, never stored
      drive(1, 1, 9'h1FF, '1, 1, 0);
      repeat (3) begin
         @(negedge clk);
         chk("kill_rdy", 160'(in_ready), 160'(1));
         chk("kill_vld", 160'(out_valid), 160'(0));
         chk("kill_ctrl", 160'(out_ctrl), 160'(0));
      end

      // Asynchronous reset with occupancy 2
      drive(1, 0, 9'h061, 148'h61, 0, 0);
      @(negedge clk); drive(1, 0, 9'h062, 148'h62, 0, 0);
      @(negedge clk); chk("rst_pre_occ", 160'(occupancy), 160'(2));
      #2 rst = 1'b1;
      #1;
      chk("arst_vld", 160'(out_valid), 160'(0));
      chk("arst_ctrl", 160'(out_ctrl), 160'(0));
      chk("arst_occ", 160'(occupancy), 160'(0));
      chk("arst_rdy", 160'(in_ready), 160'(1));
      @(negedge clk); rst = 1'b0; drive(0, 0, '0, '0, 1, 0);
      @(negedge clk); chk("arst_after", 160'(occupancy), 160'(0));

      // Randomized traffic
      for (int i = 0; i < 10000; i++) begin
         drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
               CW'($urandom),
               DW'({$urandom, $urandom, $urandom, $urandom, $urandom}),
               ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
         @(negedge clk);
      end
      drive(0, 0, '0, '0, 1, 0);
      repeat (3) @(negedge clk);
      chk("final_empty", 160'(occupancy), 160'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
